// File: rtl/csr_exec_pkg.sv
// Shared constants and types for the Zicsr execution stage.
// Optional feature macro used by the RTL: CSR_EXEC_ILLEGAL_EN.
package csr_exec_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned F3_W   = 3;

    localparam logic [F3_W-1:0] INST_CSRRW  = 3'b001;
    localparam logic [F3_W-1:0] INST_CSRRS  = 3'b010;
    localparam logic [F3_W-1:0] INST_CSRRC  = 3'b011;
    localparam logic [F3_W-1:0] INST_CSRRWI = 3'b101;
    localparam logic [F3_W-1:0] INST_CSRRSI = 3'b110;
    localparam logic [F3_W-1:0] INST_CSRRCI = 3'b111;

    // addr[11:10] == 2'b11 marks a read-only CSR
    localparam logic [CSR_AW-1:0] CSR_RO_MASK = 12'hC00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic csr_is_ro(input logic [CSR_AW-1:0] addr);
        return (addr & CSR_RO_MASK) == CSR_RO_MASK;
    endfunction

    // funct3 000 and 100 carry no Zicsr operation
    function automatic logic f3_is_legal(input logic [F3_W-1:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational Zicsr modify step: new CSR value and write enable.
// Feature macro CSR_EXEC_ILLEGAL_EN does not affect this block.
module csr_alu
    import csr_exec_pkg::*;
(
    input  logic [F3_W-1:0]   i_funct3,
    input  logic [XLEN-1:0]   i_old,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [REG_AW-1:0] i_uimm,
    output logic [XLEN-1:0]   o_new,
    output logic              o_we
);

    logic [XLEN-1:0] w_operand;

    // funct3[2] selects the zero-extended immediate form
    assign w_operand = i_funct3[2] ? XLEN'(i_uimm) : i_rs1_data;

    always_comb begin
        o_new = i_old;
        o_we  = 1'b0;
        case (i_funct3[1:0])
            2'b01: begin
                o_new = w_operand;
                o_we  = 1'b1;
            end
            2'b10: begin
                o_new = i_old | w_operand;
                o_we  = |i_uimm;
            end
            2'b11: begin
                o_new = i_old & ~w_operand;
                o_we  = |i_uimm;
            end
            default: begin
                o_new = i_old;
                o_we  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec.sv
// Zicsr sequencing stage: IDLE -> RD -> EX -> (WB) read-modify-write of the CSR file.
// Define CSR_EXEC_ILLEGAL_EN to trap writes to read-only CSRs and unused funct3.
module csr_exec
    import csr_exec_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [F3_W-1:0]   i_funct3,
    input  logic [CSR_AW-1:0] i_csr_addr,
    input  logic [REG_AW-1:0] i_rs1_addr_uimm,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic [XLEN-1:0]   i_rs1_data,
    output logic [CSR_AW-1:0] o_csr_raddr,
    input  logic [XLEN-1:0]   i_csr_rdata,
    output logic              o_csr_we,
    output logic [CSR_AW-1:0] o_csr_waddr,
    output logic [XLEN-1:0]   o_csr_wdata,
    output logic              o_wb_valid,
    input  logic              i_wb_ready,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_illegal
);

    state_t              r_state;
    logic [F3_W-1:0]     r_funct3;
    logic [CSR_AW-1:0]   r_addr;
    logic [REG_AW-1:0]   r_uimm;
    logic [REG_AW-1:0]   r_rd;
    logic [XLEN-1:0]     r_rs1_data;
    logic [REG_AW-1:0]   r_rd_addr;
    logic [XLEN-1:0]     r_rd_data;

    logic [XLEN-1:0]     w_new;
    logic                w_alu_we;
    logic                w_illegal;
    logic                w_in_ex;

    csr_alu u_alu (
        .i_funct3   (r_funct3),
        .i_old      (i_csr_rdata),
        .i_rs1_data (r_rs1_data),
        .i_uimm     (r_uimm),
        .o_new      (w_new),
        .o_we       (w_alu_we)
    );

    assign w_in_ex = (r_state == ST_EX);

`ifdef CSR_EXEC_ILLEGAL_EN
    assign w_illegal = (w_alu_we && csr_is_ro(r_addr)) || !f3_is_legal(r_funct3);
    assign o_illegal = w_in_ex && w_illegal && !i_rst;
`else
    assign w_illegal = 1'b0;
    assign o_illegal = 1'b0;
`endif

    // Write data depends on the read returning in EX, so the strobe is decoded from state
    assign o_csr_we    = w_in_ex && w_alu_we && !w_illegal && !i_rst;
    assign o_csr_waddr = r_addr;
    assign o_csr_wdata = w_new;
    assign o_csr_raddr = r_addr;
    assign o_ready     = (r_state == ST_IDLE);
    assign o_wb_valid  = (r_state == ST_WB);
    assign o_rd_addr   = r_rd_addr;
    assign o_rd_data   = r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_uimm     <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_funct3   <= i_funct3;
                        r_addr     <= i_csr_addr;
                        r_uimm     <= i_rs1_addr_uimm;
                        r_rd       <= i_rd_addr;
                        r_rs1_data <= i_rs1_data;
                        r_state    <= ST_RD;
                    end
                end
                ST_RD: r_state <= ST_EX;
                ST_EX: begin
                    r_rd_addr <= r_rd;
                    r_rd_data <= i_csr_rdata;
                    if ((r_rd != '0) && f3_is_legal(r_funct3) && !w_illegal) begin
                        r_state <= ST_WB;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    if (i_wb_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
